// File: rtl/hsv_blob_tracker_if.sv
// Pixel/config stream into the blob tracker and its mask/result stream out.
interface hsv_blob_tracker_if #(
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int CNT_W = 20
);
  logic             sof;
  logic             eof;
  logic             pix_valid;
  logic [23:0]      hsv;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [8:0]       hue_lo;
  logic [8:0]       hue_hi;
  logic [6:0]       sat_min;
  logic [7:0]       val_min;
  logic             mask_valid;
  logic             mask;
  logic [XW-1:0]    box_x0;
  logic [XW-1:0]    box_x1;
  logic [YW-1:0]    box_y0;
  logic [YW-1:0]    box_y1;
  logic [CNT_W-1:0] pix_count;
  logic             found;
  logic             result_valid;
  logic             frame_err;

  modport master (
    output sof, eof, pix_valid, hsv, x, y, hue_lo, hue_hi, sat_min, val_min,
    input  mask_valid, mask, box_x0, box_x1, box_y0, box_y1, pix_count, found,
           result_valid, frame_err
  );

  modport slave (
    input  sof, eof, pix_valid, hsv, x, y, hue_lo, hue_hi, sat_min, val_min,
    output mask_valid, mask, box_x0, box_x1, box_y0, box_y1, pix_count, found,
           result_valid, frame_err
  );
endinterface

// File: rtl/hsv_blob_tracker.sv
// HSV colour-window thresholding with a 1-cycle mask stream and a per-frame
// bounding box / matched-pixel count published two cycles after eof.
module hsv_blob_tracker #(
  parameter int XW         = 11,
  parameter int YW         = 10,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 64
)(
  input  logic              clk,
  input  logic              reset,
  hsv_blob_tracker_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_n;

  logic [8:0] sh_lo, sh_hi, lo, hi, h;
  logic [6:0] sh_sat, smin, s;
  logic [7:0] sh_val, vmin, v;
  logic       hue_ok, match;

  logic          s1_vld, s1_mask, s1_sof, s1_eof;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  logic [XW-1:0]    min_x, max_x, min_x_n, max_x_n;
  logic [YW-1:0]    min_y, max_y, min_y_n, max_y_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             active, publish, ferr;

  // The sof pixel already belongs to the new frame, so it sees the incoming
  // config rather than the stale shadow.
  always_comb begin
    lo   = bus.sof ? bus.hue_lo  : sh_lo;
    hi   = bus.sof ? bus.hue_hi  : sh_hi;
    smin = bus.sof ? bus.sat_min : sh_sat;
    vmin = bus.sof ? bus.val_min : sh_val;
    h    = bus.hsv[23:15];
    s    = bus.hsv[14:8];
    v    = bus.hsv[7:0];
    if (h >= 9'd360)  hue_ok = 1'b0;
    else if (lo <= hi) hue_ok = (h >= lo) && (h <= hi);
    else               hue_ok = (h >= lo) || (h <= hi);
    match = bus.pix_valid && hue_ok && (s >= smin) && (v >= vmin);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_lo  <= '0;
      sh_hi  <= '0;
      sh_sat <= '0;
      sh_val <= '0;
    end else if (bus.sof) begin
      sh_lo  <= bus.hue_lo;
      sh_hi  <= bus.hue_hi;
      sh_sat <= bus.sat_min;
      sh_val <= bus.val_min;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_mask <= 1'b0;
      s1_sof  <= 1'b0;
      s1_eof  <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else begin
      s1_vld  <= bus.pix_valid;
      s1_mask <= match;
      s1_sof  <= bus.sof;
      s1_eof  <= bus.eof;
      s1_x    <= bus.x;
      s1_y    <= bus.y;
    end
  end

  assign bus.mask_valid = s1_vld;
  assign bus.mask       = s1_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Init first, then include the stage-1 pixel, then publish on eof_d.
  always_comb begin
    state_n = state;
    min_x_n = min_x;
    max_x_n = max_x;
    min_y_n = min_y;
    max_y_n = max_y;
    cnt_n   = cnt;
    active  = 1'b0;
    publish = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: if (s1_sof) begin
        active  = 1'b1;
        state_n = ACCUM;
      end
      ACCUM: begin
        active = 1'b1;
        ferr   = s1_sof;
      end
      default: state_n = IDLE;
    endcase
    if (s1_sof) begin
      min_x_n = '1;
      max_x_n = '0;
      min_y_n = '1;
      max_y_n = '0;
      cnt_n   = '0;
    end
    if (active && s1_mask) begin
      if (s1_x < min_x_n) min_x_n = s1_x;
      if (s1_x > max_x_n) max_x_n = s1_x;
      if (s1_y < min_y_n) min_y_n = s1_y;
      if (s1_y > max_y_n) max_y_n = s1_y;
      if (cnt_n != '1) cnt_n = cnt_n + 1'b1;
    end
    if (active && s1_eof) begin
      publish = 1'b1;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
      cnt   <= '0;
    end else begin
      min_x <= min_x_n;
      max_x <= max_x_n;
      min_y <= min_y_n;
      max_y <= max_y_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.box_x0       <= '0;
      bus.box_x1       <= '0;
      bus.box_y0       <= '0;
      bus.box_y1       <= '0;
      bus.pix_count    <= '0;
      bus.found        <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      bus.result_valid <= publish;
      bus.frame_err    <= ferr;
      if (publish) begin
        bus.pix_count <= cnt_n;
        bus.found     <= (64'(cnt_n) >= 64'(MIN_PIXELS));
        // An empty frame reports a zero box rather than the init sentinels.
        if (cnt_n == '0) begin
          bus.box_x0 <= '0;
          bus.box_x1 <= '0;
          bus.box_y0 <= '0;
          bus.box_y1 <= '0;
        end else begin
          bus.box_x0 <= min_x_n;
          bus.box_x1 <= max_x_n;
          bus.box_y0 <= min_y_n;
          bus.box_y1 <= max_y_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Randomised and directed bench for hsv_blob_tracker against a frame-level model.
module tb_hsv_blob_tracker;
  localparam int XW = 11, YW = 10, CW = 20, CW4 = 4;
  localparam int PW  = 2*XW + 2*YW + CW  + 1;
  localparam int PW4 = 2*XW + 2*YW + CW4 + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hsv_blob_tracker_if #(.XW(XW), .YW(YW), .CNT_W(CW))  ifc();
  hsv_blob_tracker_if #(.XW(XW), .YW(YW), .CNT_W(CW4)) ifc4();

  hsv_blob_tracker #(.XW(XW), .YW(YW), .CNT_W(CW), .MIN_PIXELS(64)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave));
  hsv_blob_tracker #(.XW(XW), .YW(YW), .CNT_W(CW4), .MIN_PIXELS(64)) dut4 (
    .clk(clk), .reset(reset), .bus(ifc4.slave));

  assign ifc4.sof       = ifc.sof;
  assign ifc4.eof       = ifc.eof;
  assign ifc4.pix_valid = ifc.pix_valid;
  assign ifc4.hsv       = ifc.hsv;
  assign ifc4.x         = ifc.x;
  assign ifc4.y         = ifc.y;
  assign ifc4.hue_lo    = ifc.hue_lo;
  assign ifc4.hue_hi    = ifc.hue_hi;
  assign ifc4.sat_min   = ifc.sat_min;
  assign ifc4.val_min   = ifc.val_min;

  logic [PW-1:0]  got_pub;
  logic [PW4-1:0] got4;
  assign got_pub = {ifc.box_x0, ifc.box_x1, ifc.box_y0, ifc.box_y1, ifc.pix_count, ifc.found};
  assign got4    = {ifc4.box_x0, ifc4.box_x1, ifc4.box_y0, ifc4.box_y1, ifc4.pix_count, ifc4.found};

  int checks = 0, failures = 0;
  int rv_cnt = 0, ferr_cnt = 0, exp_ferr = 0;

  always @(posedge clk) begin
    if (ifc.result_valid) rv_cnt   <= rv_cnt + 1;
    if (ifc.frame_err)    ferr_cnt <= ferr_cnt + 1;
  end

  // Frame-level reference state
  int cfg_lo, cfg_hi, cfg_s, cfg_v;
  bit m_active;
  int m_x0, m_x1, m_y0, m_y1, m_cnt;
  int p_x0, p_x1, p_y0, p_y1, p_cnt;

  function automatic int sat(int c, int w);
    int m = (1 << w) - 1;
    return (c > m) ? m : c;
  endfunction

  function automatic bit ref_match(int h, int s, int v);
    bit in_hue;
    if (h > 359) return 1'b0;
    if (cfg_lo <= cfg_hi) in_hue = (h >= cfg_lo) && (h <= cfg_hi);
    else                  in_hue = !((h > cfg_hi) && (h < cfg_lo));
    return in_hue && (s >= cfg_s) && (v >= cfg_v);
  endfunction

  function automatic logic [PW-1:0] exp_pub();
    int c = sat(p_cnt, CW);
    return {XW'(p_x0), XW'(p_x1), YW'(p_y0), YW'(p_y1), CW'(c), (c >= 64)};
  endfunction

  function automatic logic [PW4-1:0] exp_pub4();
    int c = sat(p_cnt, CW4);
    return {XW'(p_x0), XW'(p_x1), YW'(p_y0), YW'(p_y1), CW4'(c), (c >= 64)};
  endfunction

  task automatic model_clear();
    cfg_lo = 0; cfg_hi = 0; cfg_s = 0; cfg_v = 0;
    m_active = 1'b0; m_cnt = 0;
    p_x0 = 0; p_x1 = 0; p_y0 = 0; p_y1 = 0; p_cnt = 0;
  endtask

  task automatic set_window(input int lo, hi, s, v);
    ifc.hue_lo  = 9'(lo);
    ifc.hue_hi  = 9'(hi);
    ifc.sat_min = 7'(s);
    ifc.val_min = 8'(v);
  endtask

  // Drives one pixel slot, advances the model, and checks the mask one cycle later.
  task automatic run_pixel(input string nm, input bit sf, ef, pv, input int h, s, v, px, py);
    bit em;
    logic [8:0] hh;
    logic [6:0] ss;
    logic [7:0] vv;
    hh = h[8:0]; ss = s[6:0]; vv = v[7:0];
    ifc.sof = sf; ifc.eof = ef; ifc.pix_valid = pv;
    ifc.hsv = {hh, ss, vv};
    ifc.x = px[XW-1:0];
    ifc.y = py[YW-1:0];
    if (sf) begin
      cfg_lo = int'(ifc.hue_lo); cfg_hi = int'(ifc.hue_hi);
      cfg_s  = int'(ifc.sat_min); cfg_v = int'(ifc.val_min);
    end
    em = pv && ref_match(h, s, v);
    if (sf) begin
      if (m_active) exp_ferr++;
      m_active = 1'b1;
      m_x0 = 1 << 30; m_x1 = -1; m_y0 = 1 << 30; m_y1 = -1; m_cnt = 0;
    end
    if (m_active && em) begin
      if (px < m_x0) m_x0 = px;
      if (px > m_x1) m_x1 = px;
      if (py < m_y0) m_y0 = py;
      if (py > m_y1) m_y1 = py;
      m_cnt++;
    end
    if (m_active && ef) begin
      m_active = 1'b0;
      p_cnt = m_cnt;
      if (m_cnt == 0) begin
        p_x0 = 0; p_x1 = 0; p_y0 = 0; p_y1 = 0;
      end else begin
        p_x0 = m_x0; p_x1 = m_x1; p_y0 = m_y0; p_y1 = m_y1;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.mask !== em || ifc.mask_valid !== pv) begin
      failures++;
      $display("FAIL %s mask: got mask=%b valid=%b, want mask=%b valid=%b",
               nm, ifc.mask, ifc.mask_valid, em, pv);
    end
  endtask

  // Called right after the eof slot: result must arrive exactly one slot later, pulse once, then hold.
  task automatic close_frame(input string nm);
    logic [PW-1:0]  e;
    logic [PW4-1:0] e4;
    checks++;
    if (ifc.result_valid !== 1'b0) begin
      failures++; $display("FAIL %s early_result: got rv=%b want 0", nm, ifc.result_valid);
    end
    run_pixel(nm, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    e = exp_pub(); e4 = exp_pub4();
    checks++;
    if (ifc.result_valid !== 1'b1 || ifc4.result_valid !== 1'b1) begin
      failures++; $display("FAIL %s result_valid: got %b/%b want 1/1", nm, ifc.result_valid, ifc4.result_valid);
    end
    checks++;
    if (got_pub !== e) begin
      failures++; $display("FAIL %s publish: got %h want %h", nm, got_pub, e);
    end
    checks++;
    if (got4 !== e4) begin
      failures++; $display("FAIL %s publish_cnt4: got %h want %h", nm, got4, e4);
    end
    run_pixel(nm, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.result_valid !== 1'b0 || got_pub !== e) begin
      failures++; $display("FAIL %s hold: got rv=%b pub=%h want rv=0 pub=%h", nm, ifc.result_valid, got_pub, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (got_pub !== '0 || got4 !== '0 || ifc.mask !== 1'b0 || ifc.mask_valid !== 1'b0 ||
        ifc.result_valid !== 1'b0 || ifc.frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_state: got pub=%h mask=%b mv=%b rv=%b fe=%b want all 0",
                           got_pub, ifc.mask, ifc.mask_valid, ifc.result_valid, ifc.frame_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    set_window(200, 250, 100, 100);   // not sampled: no sof yet
    run_pixel("shadow_zero_h0", 1'b0, 1'b0, 1'b1, 0, 0, 0, 1, 1);
    checks++;
    if (ifc.mask !== 1'b1) begin failures++; $display("FAIL shadow_zero_h0: got %b want 1", ifc.mask); end
    run_pixel("shadow_zero_h5", 1'b0, 1'b0, 1'b1, 5, 0, 0, 1, 1);
    checks++;
    if (ifc.mask !== 1'b0) begin failures++; $display("FAIL shadow_zero_h5: got %b want 0", ifc.mask); end
  endtask

  task automatic test_hue_window();
    int  hs[5] = '{120, 99, 120, 120, 370};
    int  ss[5] = '{64, 64, 19, 64, 64};
    int  vs[5] = '{200, 200, 200, 29, 200};
    bit  ex[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    set_window(100, 140, 20, 30);
    for (int i = 0; i < 5; i++) begin
      run_pixel("hue_window", i == 0, i == 4, 1'b1, hs[i], ss[i], vs[i], i, 0);
      checks++;
      if (ifc.mask !== ex[i]) begin failures++; $display("FAIL hue_window[%0d]: got %b want %b", i, ifc.mask, ex[i]); end
    end
    close_frame("hue_window");
  endtask

  task automatic test_wrap_window();
    int hs[4] = '{350, 5, 180, 359};
    bit ex[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    set_window(340, 20, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_pixel("wrap_window", i == 0, i == 3, 1'b1, hs[i], 10, 10, 10 + i, 3);
      checks++;
      if (ifc.mask !== ex[i]) begin failures++; $display("FAIL wrap_window[%0d]: got %b want %b", i, ifc.mask, ex[i]); end
    end
    close_frame("wrap_window");
  endtask

  task automatic test_box();
    set_window(100, 140, 20, 30);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        bit hit = (c == 2 && r == 3) || (c == 5 && r == 1) || (c == 6 && r == 7);
        run_pixel("box", r == 0 && c == 0, r == 7 && c == 7, 1'b1, hit ? 120 : 200, 64, 200, c, r);
      end
    close_frame("box");
    checks++;
    if (ifc.box_x0 !== 11'd2 || ifc.box_y0 !== 10'd1 || ifc.box_x1 !== 11'd6 || ifc.box_y1 !== 10'd7 ||
        ifc.pix_count !== 20'd3 || ifc.found !== 1'b0) begin
      failures++; $display("FAIL box_const: got (%0d,%0d)-(%0d,%0d) n=%0d f=%b want (2,1)-(6,7) n=3 f=0",
                           ifc.box_x0, ifc.box_y0, ifc.box_x1, ifc.box_y1, ifc.pix_count, ifc.found);
    end
  endtask

  task automatic test_saturation();
    set_window(100, 140, 20, 30);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        run_pixel("saturation", r == 0 && c == 0, r == 9 && c == 9, 1'b1, 120, 64, 200, 100 + c, 50 + r);
    close_frame("saturation");
    checks++;
    if (ifc.pix_count !== 20'd100 || ifc.found !== 1'b1 || ifc4.pix_count !== 4'd15 || ifc4.found !== 1'b0) begin
      failures++; $display("FAIL saturation_const: got n=%0d f=%b n4=%0d f4=%b want 100 1 15 0",
                           ifc.pix_count, ifc.found, ifc4.pix_count, ifc4.found);
    end
  endtask

  task automatic test_shadow();
    set_window(100, 140, 20, 30);
    run_pixel("shadow", 1'b1, 1'b0, 1'b1, 120, 64, 200, 4, 4);
    ifc.hue_lo = 9'd130;
    run_pixel("shadow", 1'b0, 1'b0, 1'b1, 120, 64, 200, 5, 4);
    checks++;
    if (ifc.mask !== 1'b1) begin failures++; $display("FAIL shadow_midframe: got %b want 1", ifc.mask); end
    run_pixel("shadow", 1'b0, 1'b1, 1'b0, 0, 0, 0, 6, 4);
    close_frame("shadow");
    run_pixel("shadow2", 1'b1, 1'b0, 1'b1, 120, 64, 200, 4, 4);
    checks++;
    if (ifc.mask !== 1'b0) begin failures++; $display("FAIL shadow_newframe: got %b want 0", ifc.mask); end
    run_pixel("shadow2", 1'b0, 1'b1, 1'b1, 135, 64, 200, 9, 9);
    close_frame("shadow2");
  endtask

  task automatic test_frame_err();
    int f0 = ferr_cnt, r0 = rv_cnt;
    set_window(100, 140, 20, 30);
    run_pixel("frame_err", 1'b1, 1'b0, 1'b1, 120, 64, 200, 1, 1);
    run_pixel("frame_err", 1'b0, 1'b0, 1'b1, 120, 64, 200, 2, 2);
    run_pixel("frame_err", 1'b1, 1'b0, 1'b1, 120, 64, 200, 5, 5);
    run_pixel("frame_err", 1'b0, 1'b0, 1'b1, 200, 64, 200, 6, 6);
    checks++;
    if (ifc.frame_err !== 1'b1 || ifc.result_valid !== 1'b0) begin
      failures++; $display("FAIL frame_err_pulse: got fe=%b rv=%b want 1 0", ifc.frame_err, ifc.result_valid);
    end
    run_pixel("frame_err", 1'b0, 1'b1, 1'b1, 125, 64, 200, 3, 4);
    checks++;
    if (ifc.frame_err !== 1'b0) begin failures++; $display("FAIL frame_err_width: got %b want 0", ifc.frame_err); end
    close_frame("frame_err");
    checks++;
    if (ferr_cnt - f0 != 1 || exp_ferr != 1 || rv_cnt - r0 != 1 || p_cnt != 2) begin
      failures++; $display("FAIL frame_err_counts: got ferr=%0d rv=%0d n=%0d want 1 1 2", ferr_cnt - f0, rv_cnt - r0, p_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int r0;
    set_window(100, 140, 20, 30);
    run_pixel("rst_mid", 1'b1, 1'b0, 1'b1, 120, 64, 200, 7, 7);
    run_pixel("rst_mid", 1'b0, 1'b0, 1'b1, 120, 64, 200, 8, 7);
    reset = 1'b1;
    #2;
    checks++;
    if (got_pub !== '0 || got4 !== '0 || ifc.mask !== 1'b0 || ifc.mask_valid !== 1'b0 || ifc.result_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs: got pub=%h mask=%b mv=%b rv=%b want 0", got_pub, ifc.mask, ifc.mask_valid, ifc.result_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    r0 = rv_cnt;
    run_pixel("rst_mid_tail", 1'b0, 1'b0, 1'b1, 0, 10, 10, 9, 7);
    run_pixel("rst_mid_tail", 1'b0, 1'b1, 1'b1, 0, 10, 10, 9, 8);
    run_pixel("rst_mid_tail", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    run_pixel("rst_mid_tail", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    run_pixel("rst_mid_tail", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (rv_cnt != r0 || got_pub !== '0) begin
      failures++; $display("FAIL rst_mid_no_publish: got rv=%0d pub=%h want 0 and 0", rv_cnt - r0, got_pub);
    end
    run_pixel("rst_mid_next", 1'b1, 1'b0, 1'b1, 110, 64, 200, 3, 3);
    run_pixel("rst_mid_next", 1'b0, 1'b1, 1'b1, 130, 64, 200, 4, 9);
    close_frame("rst_mid_next");
  endtask

  task automatic test_one_pixel();
    set_window(100, 140, 20, 30);
    run_pixel("one_pixel", 1'b1, 1'b1, 1'b1, 120, 64, 200, 33, 44);
    close_frame("one_pixel");
    checks++;
    if (ifc.pix_count !== 20'd1 || ifc.box_x0 !== 11'd33 || ifc.box_y1 !== 10'd44) begin
      failures++; $display("FAIL one_pixel_const: got n=%0d x0=%0d y1=%0d want 1 33 44", ifc.pix_count, ifc.box_x0, ifc.box_y1);
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] ea;
    set_window(100, 140, 20, 30);
    run_pixel("b2b_a", 1'b1, 1'b0, 1'b1, 120, 64, 200, 1, 1);
    run_pixel("b2b_a", 1'b0, 1'b1, 1'b1, 120, 64, 200, 4, 2);
    ea = exp_pub();
    run_pixel("b2b_b", 1'b1, 1'b0, 1'b1, 120, 64, 200, 7, 5);
    checks++;
    if (ifc.result_valid !== 1'b1 || got_pub !== ea) begin
      failures++; $display("FAIL b2b_publish: got rv=%b pub=%h want 1 %h", ifc.result_valid, got_pub, ea);
    end
    run_pixel("b2b_b", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    close_frame("b2b_b");
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int w   = int'($urandom_range(3, 8));
      int hg  = int'($urandom_range(2, 6));
      int ox  = int'($urandom_range(0, 1900));
      int oy  = int'($urandom_range(0, 1000));
      set_window(int'($urandom_range(0, 359)), int'($urandom_range(0, 359)),
                 int'($urandom_range(0, 60)), int'($urandom_range(0, 120)));
      for (int r = 0; r < hg; r++)
        for (int c = 0; c < w; c++) begin
          bit sf = (r == 0 && c == 0);
          bit ef = (r == hg - 1 && c == w - 1);
          int h  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 359));
          if (!sf && $urandom_range(0, 9) == 0) begin
            ifc.hue_lo  = 9'($urandom_range(0, 359));
            ifc.sat_min = 7'($urandom_range(0, 127));
          end
          run_pixel("random", sf, ef, $urandom_range(0, 4) != 0, h,
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), ox + c, oy + r);
        end
      close_frame("random");
    end
  endtask

  initial begin
    reset = 1'b1;
    ifc.sof = 1'b0; ifc.eof = 1'b0; ifc.pix_valid = 1'b0;
    ifc.hsv = '0; ifc.x = '0; ifc.y = '0;
    set_window(0, 0, 0, 0);
    model_clear();
    test_reset();
    test_hue_window();
    test_wrap_window();
    test_box();
    test_saturation();
    test_shadow();
    test_frame_err();
    test_reset_midframe();
    test_one_pixel();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hsv_blob_tracker.md
Name: hsv_blob_tracker

Overview:
- Sits directly downstream of the combinational RGB-to-HSV converter in the D8M video path.
- Consumes the packed HSV word per pixel: H[23:15] is 0..359, S[14:8] is 0..127, V[7:0] is 0..255.
- Thresholds each pixel against a programmable colour window and emits a 1-cycle-latency mask stream for overlay.
- Accumulates a per-frame bounding box and matched-pixel count, and publishes them once per frame for the tracking logic.

Parameters:
XW, 11, width of the pixel x coordinate.
YW, 10, width of the pixel y coordinate.
CNT_W, 20, width of the matched-pixel counter; the counter saturates.
MIN_PIXELS, 64, minimum matched count for found=1.

Ports:
clk  in  1  pixel clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-high reset.
sof  in  1  start-of-frame pulse, 1 cycle, coincident with the first pixel slot.
eof  in  1  end-of-frame pulse, 1 cycle, coincident with the last pixel slot.
pix_valid  in  1  hsv, x and y are valid this cycle.
hsv  in  24  {H[8:0], S[6:0], V[7:0]} from the converter.
x  in  XW  pixel column.
y  in  YW  pixel row.
hue_lo  in  9  lower hue bound, inclusive.
hue_hi  in  9  upper hue bound, inclusive; hue_lo>hue_hi selects the wrap-around window.
sat_min  in  7  minimum saturation, inclusive.
val_min  in  8  minimum value, inclusive.
mask_valid  out  1  pix_valid delayed 1 cycle.
mask  out  1  pixel matched the window; delayed 1 cycle.
box_x0, box_x1  out  XW each  published min and max x.
box_y0, box_y1  out  YW each  published min and max y.
pix_count  out  CNT_W  published matched count.
found  out  1  published pix_count>=MIN_PIXELS.
result_valid  out  1  1-cycle pulse when new results are published.
frame_err  out  1  1-cycle pulse on a sof received while in ACCUM.

Behaviour:
- Reset: every output and accumulator is 0 and the FSM enters IDLE. Reset asserted mid-frame discards that frame, and no result is published for it.
- Config latching:
  - hue_lo, hue_hi, sat_min and val_min are sampled into shadow registers on the cycle sof is high.
  - Changes to these inputs mid-frame have no effect until the next sof.
  - Before the first sof after reset, the shadow registers are 0.
- Match function, on the shadow values:
  - H>=360 never matches.
  - If lo<=hi: hue_ok = lo<=H<=hi. Otherwise hue_ok = H>=lo or H<=hi.
  - match = hue_ok and S>=sat_min and V>=val_min.
- Stage 1, latency 1: mask_valid, mask, registered x/y, sof_d and eof_d are registered every cycle. The mask stream runs regardless of FSM state. mask=0 whenever pix_valid=0.
- FSM states:
  - IDLE: ignores stage-1 pixels. On sof_d, loads the init values and goes to ACCUM.
  - ACCUM: accumulates. On eof_d, publishes and goes to IDLE. On sof_d without a prior eof_d, pulses frame_err, re-inits without publishing, and stays in ACCUM.
- Init values: min_x/min_y are all-ones, max_x/max_y are 0, count is 0.
- sof_d and a matching pixel in the same cycle: init is applied, then that pixel is included. The loaded value is that pixel's coordinates and count=1.
- Accumulate, on a stage-1 pixel with mask=1 in ACCUM:
  - min_x=min(min_x,x), max_x=max(max_x,x), and likewise for y.
  - count+1, saturating at 2^CNT_W-1 with no wrap.
- eof_d and a matching pixel in the same cycle: that pixel is included in the published result.
- Publish, on the cycle after eof_d:
  - Outputs register the final accumulators and result_valid=1 for exactly 1 cycle.
  - If count=0, the box outputs are all 0 and found=0.
  - found=(count>=MIN_PIXELS).
- Published outputs hold until the next publish or reset.
- sof and eof in the same cycle, a 1-pixel frame: init, include, publish. Next state is IDLE.
- Latency: pixel-to-mask is 1 cycle; eof-to-result_valid is 2 cycles.

Test Plan:
- Hue window: lo=100, hi=140, sat_min=20, val_min=30.
  - Pixels (H,S,V) = (120,64,200) -> mask=1.
  - (99,64,200) -> 0.
  - (120,19,200) -> 0.
  - (120,64,29) -> 0.
  - (370,64,200) -> 0.
- Wrap window: lo=340, hi=20.
  - H=350 -> mask=1; H=5 -> 1; H=180 -> 0; H=359 -> 1.
- Box:
  - 8x8 frame with matches at (2,3), (5,1) and (6,7) -> 2 cycles after eof: box=(2,1)-(6,7), pix_count=3.
  - found=0 with MIN_PIXELS=64.
  - result_valid is high 1 cycle.
- Saturation and threshold:
  - All 100 pixels match -> pix_count=100, found=1.
  - With CNT_W=4 -> pix_count=15.
- Config shadowing: change hue_lo mid-frame -> mask within that frame still uses the sof-time value.
- Errors and reset:
  - sof mid-frame -> frame_err pulse, no result_valid, next frame correct.
  - reset mid-frame -> all outputs 0, no result_valid until a full sof..eof completes.
